// File: rtl/mem_bus_pkg.sv
//------------------------------------------------------------------------------
// mem_bus_pkg
//   Shared constants and types for the byte-wide CPU memory bus responder:
//   IO region base and register offsets, bus direction encoding and the halt
//   state machine encoding.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_bus_pkg;

  // Base of the memory-mapped IO region; everything below it is RAM.
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  // IO register offsets relative to IO_BASE.
  localparam logic [31:0] IO_UART = 32'd0;
  localparam logic [31:0] IO_HALT = 32'd4;

  // Bus direction as seen on mem_wr.
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  // Halt sequencing: run normally, drain the TX FIFO, then stop for good.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_responder_byte_fifo.sv
//------------------------------------------------------------------------------
// byte_fifo
//   Circular FIFO with wrapping head/tail pointers and an occupancy counter.
//   A pop on a full FIFO frees a slot for a push in the same cycle. There is
//   no bypass: a byte pushed into an empty FIFO appears at the head one cycle
//   later. afull_o is a registered "count >= AFULL_TH" flag that tracks the
//   occupancy in the same cycle the count changes.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset (flushes)
//     push_i, data_i  write request and data
//     pop_i           read request (ignored when empty)
//     data_o          head entry, zero when empty
//     count_o         occupancy, 0..DEPTH
//     full_o/empty_o  occupancy flags
//     afull_o         registered almost-full flag
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module byte_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AFULL_TH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       afull_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);
  localparam logic [PW:0] C_AFULL = (PW+1)'(AFULL_TH);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [PW:0]      count_q;
  logic [PW:0]      count_d;
  logic             afull_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == C_DEPTH);
  assign pop_ok  = pop_i && !empty_o;
  // Full FIFO still accepts a push when a pop frees the head slot this cycle.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      afull_q <= 1'b0;
    end else begin
      if (push_ok) tail_q <= tail_q + 1'b1;
      if (pop_ok)  head_q <= head_q + 1'b1;
      count_q <= count_d;
      afull_q <= (count_d >= C_AFULL);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= data_i;
  end

  assign data_o  = empty_o ? '0 : mem_q[head_q];
  assign count_o = count_q;
  assign afull_o = afull_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
//------------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU byte bus. Serves one byte per cycle:
//   RAM below IO_BASE (upper address bits alias), memory-mapped IO at and
//   above IO_BASE (TX FIFO toward the UART, RX byte input, halt register).
//   Read data is registered and appears on mem_din one cycle after the
//   address; mem_din holds on write cycles.
//
//   Optional build macro MEM_RESPONDER_CYCLE_CNT_EN adds a free-running
//   32-bit cycle counter readable at IO_BASE+4..+7; a read of +4 snapshots
//   the counter so the upper bytes read back coherently.
//
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     mem_a, mem_wr, mem_dout     initiator address, direction, write data
//     mem_din                     registered read data
//     io_buffer_full              TX FIFO nearly full (CPU stall)
//     tx_valid, tx_data, tx_ready TX FIFO head handshake toward the UART
//     rx_valid, rx_data, rx_pop   RX byte input and its consume pulse
//     tx_overflow                 sticky: a TX write was dropped
//     halt                        program finished and TX drained
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = 17,
  parameter int unsigned TX_DEPTH   = 8,
  parameter logic [31:0] IO_BASE    = mem_bus_pkg::IO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        tx_overflow,
  output logic        halt
);

  localparam int unsigned CW = $clog2(TX_DEPTH) + 1;

  logic [7:0]            ram_q [0:(2**RAM_ADDR_W)-1];
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  io_sel;
  logic                  is_uart;
  logic                  is_halt;
  logic                  wr_en;
  logic                  rd_en;
  logic                  ram_we;
  logic                  tx_push;
  logic                  tx_pop;
  logic                  halt_req;
  logic [CW-1:0]         tx_count;
  logic                  tx_full;
  logic                  tx_empty;
  logic [7:0]            rd_data_d;
  logic [7:0]            mem_din_q;
  logic                  tx_overflow_q;
  halt_state_e           state_q;
  halt_state_e           state_d;

  assign ram_idx = mem_a[RAM_ADDR_W-1:0];
  assign io_sel  = (mem_a >= IO_BASE);
  assign is_uart = (mem_a == IO_BASE + IO_UART);
  assign is_halt = (mem_a == IO_BASE + IO_HALT);

  // Once halted, every write (RAM or IO) is discarded; reads keep working.
  assign wr_en    = (mem_wr == WR) && (state_q != HALTED);
  assign rd_en    = (mem_wr == RD);
  assign ram_we   = wr_en && !io_sel;
  assign tx_push  = wr_en && is_uart;
  assign halt_req = wr_en && is_halt;
  assign tx_pop   = tx_valid && tx_ready;

  // The RX byte is consumed in the address cycle, combinationally.
  assign rx_pop = !rst && rd_en && is_uart && rx_valid;

  byte_fifo #(
    .DEPTH    (TX_DEPTH),
    .WIDTH    (8),
    .AFULL_TH (TX_DEPTH - 2)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .data_i  (mem_dout),
    .pop_i   (tx_pop),
    .data_o  (tx_data),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .afull_o (io_buffer_full)
  );

  assign tx_valid = !tx_empty;

`ifdef MEM_RESPONDER_CYCLE_CNT_EN
  logic [31:0] cyc_cnt_q;
  logic [31:0] cyc_snap_q;
  logic        is_cnt0;
  logic        is_cnt1;
  logic        is_cnt2;
  logic        is_cnt3;

  assign is_cnt0 = is_halt;
  assign is_cnt1 = (mem_a == IO_BASE + IO_HALT + 32'd1);
  assign is_cnt2 = (mem_a == IO_BASE + IO_HALT + 32'd2);
  assign is_cnt3 = (mem_a == IO_BASE + IO_HALT + 32'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q  <= '0;
      cyc_snap_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
      // Byte 0 is read live; capturing here makes bytes 1..3 coherent with it.
      if (rd_en && is_cnt0) cyc_snap_q <= cyc_cnt_q;
    end
  end
`endif

  always_comb begin
    rd_data_d = 8'h00;
    if (!io_sel) begin
      rd_data_d = ram_q[ram_idx];
    end else if (is_uart) begin
      rd_data_d = rx_valid ? rx_data : 8'h00;
    end
`ifdef MEM_RESPONDER_CYCLE_CNT_EN
    else if (is_cnt0) begin
      rd_data_d = cyc_cnt_q[7:0];
    end else if (is_cnt1) begin
      rd_data_d = cyc_snap_q[15:8];
    end else if (is_cnt2) begin
      rd_data_d = cyc_snap_q[23:16];
    end else if (is_cnt3) begin
      rd_data_d = cyc_snap_q[31:24];
    end
`endif
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_din_q     <= 8'h00;
      tx_overflow_q <= 1'b0;
      state_q       <= RUN;
    end else begin
      if (rd_en) mem_din_q <= rd_data_d;
      if (tx_push && tx_full && !tx_pop) tx_overflow_q <= 1'b1;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = DRAIN;
      DRAIN:   if ((tx_count == '0) && !tx_valid) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  assign mem_din     = mem_din_q;
  assign tx_overflow = tx_overflow_q;
  assign halt        = (state_q == HALTED);

endmodule

`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus. The CPU-side memory controller is the initiator.
- Services one byte per cycle: RAM reads and writes, plus memory-mapped IO.
- IO consists of a TX byte FIFO toward the UART, an RX byte input, and a halt register.
- Produces the io_buffer_full back-pressure that the top level feeds into the CPU's rdy.

Parameters:
- RAM_ADDR_W, 17, RAM size is 2^RAM_ADDR_W bytes.
- TX_DEPTH, 8, TX FIFO depth in bytes (power of two, at least 4).
- IO_BASE, 32'h0003_0000, base address of the IO region.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_a  in  32  byte address from the initiator
- mem_wr  in  1  1 = write, 0 = read
- mem_dout  in  8  write data from the initiator
- mem_din  out  8  read data to the initiator; valid the cycle after the address
- io_buffer_full  out  1  TX FIFO nearly full; top level stalls the CPU
- tx_valid  out  1  TX FIFO head valid
- tx_data  out  8  TX FIFO head byte
- tx_ready  in  1  UART accepts the head byte
- rx_valid  in  1  input byte available
- rx_data  in  8  input byte
- rx_pop  out  1  single-cycle pulse consuming rx_data
- tx_overflow  out  1  sticky: a TX write was dropped
- halt  out  1  program finished and TX drained

Behaviour:
- Address decode:
  - IO access when mem_a >= IO_BASE; otherwise RAM at index mem_a[RAM_ADDR_W-1:0].
  - Upper RAM address bits are ignored (aliasing).
- Latency:
  - Every read returns its data on mem_din exactly 1 cycle after the address is presented.
  - mem_din is a register; it holds its value on write cycles.
- RAM:
  - Write: ram[idx] <= mem_dout at the edge.
  - Read: mem_din <= ram[idx].
  - A read of an address written in the previous cycle returns the new data.
  - Contents are not cleared by rst.
- IO read, IO_BASE+0:
  - If rx_valid: mem_din <= rx_data and rx_pop pulses in the same cycle as the address.
  - Otherwise mem_din <= 8'h00 and no pop.
- IO read, IO_BASE+4: mem_din <= 8'h00 (without CYCLE_CNT_EN).
- IO read, any other IO offset: mem_din <= 8'h00.
- IO write, IO_BASE+0: push mem_dout to the TX FIFO.
  - FIFO full: the byte is dropped and tx_overflow is set sticky until rst.
- IO write, IO_BASE+4: halt request; the FSM moves RUN -> DRAIN.
- IO write, other IO offsets: ignored.
- TX FIFO:
  - Circular, head/tail pointers of log2(TX_DEPTH) bits that wrap; count of log2(TX_DEPTH)+1 bits.
  - Pop when tx_valid && tx_ready.
  - Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push is accepted and count is unchanged.
  - Simultaneous push and pop on an empty FIFO: the byte is stored; tx_valid rises next cycle (no bypass).
  - io_buffer_full = (count >= TX_DEPTH-2), registered. The two-slot margin covers in-flight writes issued before the stall takes effect.
- Halt FSM:
  - RUN: normal operation.
  - DRAIN: entered on a halt write. Still services the bus and the TX FIFO. Goes to HALTED when count==0 && !tx_valid.
  - HALTED: halt=1. RAM and IO writes are ignored, reads are still served, TX stays idle. Only rst leaves this state.
  - Halt write in the same cycle as the last TX pop: still passes through DRAIN for one cycle.
- Reset values: mem_din=0, io_buffer_full=0, tx_valid=0, tx_data=0, rx_pop=0, tx_overflow=0, halt=0, FSM=RUN, FIFO empty.
- rst mid-operation: the FIFO is flushed and the in-flight read result is discarded (mem_din=0).

Optional Feature:
- Macro: MEM_RESPONDER_CYCLE_CNT_EN.
- With it: a free-running 32-bit cycle counter, cleared by rst, wraps at 2^32.
  - Reads of IO_BASE+4..IO_BASE+7 return counter bytes 0..3.
  - The counter is snapshotted into a shadow register on a read of IO_BASE+4, so all four bytes are coherent.
  - Bytes 1..3 come from the snapshot.
- Without it: those addresses read 8'h00 and no counter or snapshot logic exists.

Decomposition:
- Shared package mem_bus_pkg holds:
  - IO_BASE and the IO offsets IO_UART=0 and IO_HALT=4.
  - Halt FSM state typedef {RUN, DRAIN, HALTED}.
  - Bus direction constants RD=0, WR=1.
- One sub-module: byte_fifo (parameterised depth and width, push/pop/count/full/empty), instantiated for TX.

Test Plan:
- RAM read latency:
  - Write 8'hA5 to 0x100, then 8'h3C to 0x101; read both.
  - mem_din = A5 and then 3C, each 1 cycle after its address.
  - A back-to-back read of 0x100 right after its write returns A5.
- RX read:
  - rx_valid=1, rx_data=8'h41, read IO_BASE: rx_pop pulses one cycle and mem_din=41 next cycle.
  - With rx_valid=0: mem_din=00 and no rx_pop.
- TX back-pressure, TX_DEPTH=8, tx_ready=0:
  - 6 writes to IO_BASE: io_buffer_full=1 after the 6th.
  - 2 more writes: accepted, count=8.
  - 9th write: dropped and tx_overflow=1.
  - Raise tx_ready: 8 bytes are emitted in order.
- Halt drain:
  - 3 bytes queued, tx_ready=1 every other cycle, then write IO_BASE+4.
  - halt=1 only after the 3rd byte is popped.
  - A subsequent RAM write to 0x200 leaves the location unchanged.
- Wrap and simultaneous events:
  - Push/pop 20 bytes through the FIFO with tx_ready toggling; the output sequence matches the input across pointer wrap.
  - Push and pop in the same cycle on a full FIFO leaves count at 8 and does not set tx_overflow.
- Reset mid-operation and cycle counter:
  - Assert rst with 4 bytes queued: tx_valid=0, halt=0, io_buffer_full=0, mem_din=0 next cycle.
  - With MEM_RESPONDER_CYCLE_CNT_EN: reads of IO_BASE+4..7 at cycle 0x1234 after reset return 34,12,00,00.
